// File: rtl/bram_burst_ctrl_pkg.sv
// Shared types and constants for the BRAM burst controller and its read buffer.
package bram_burst_ctrl_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 8;
    localparam int RD_FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/bram_rd_fifo.sv
// Two-entry read-return buffer; head is visible combinationally, push/pop take effect on the clock edge.
// A push while full is honoured only when a pop happens in the same cycle.
module bram_rd_fifo
    import bram_burst_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_W-1:0]     mem_q [RD_FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_d [RD_FIFO_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  do_push, do_pop;

    assign full     = (count_q == FIFO_CNT_W'(RD_FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Head is forced to zero when empty so no stale beat is ever presented.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bram_burst_ctrl.sv
// Burst controller for a single-port BRAM: writes pass straight through on each wr handshake,
// reads have a 2-cycle acceptance-to-rd_valid latency and are throttled so buffer + in-flight never exceed 2.
module bram_burst_ctrl
    import bram_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wre,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;

    logic                  wr_hs;
    logic                  rd_issue;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [1:0]            fifo_room;

    bram_rd_fifo #(
        .DATA_W(DATA_W)
    ) u_rd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(mem_q),
        .pop      (fifo_pop),
        .pop_data (rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign rd_valid = !fifo_empty;
    assign fifo_pop = rd_valid && rd_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        wr_hs     = 1'b0;
        rd_issue  = 1'b0;
        req_ready = (state_q == ST_IDLE);
        wr_ready  = (state_q == ST_WRITE);

        // Free slots after this cycle's pop; a read may issue only if the outstanding one still fits too.
        fifo_room = (fifo_full ? 2'd0 : (fifo_empty ? 2'd2 : 2'd1)) + {1'b0, fifo_pop};

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_hs = wr_valid;
                if (wr_hs) begin
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q - ADDR_ONE;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                rd_issue = (fifo_room > {1'b0, inflight_q});
                if (rd_issue) begin
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q - ADDR_ONE;
                    if (cnt_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !inflight_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inflight_d = rd_issue;
    end

    assign mem_wre  = wr_hs;
    assign mem_addr = addr_q;
    assign mem_data = wr_hs ? wr_data : '0;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE) || done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/bram_burst_ctrl.md
BRAM_BURST_CTRL -- requirements
Module: bram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, BRAM address width.
REQ-002 Parameter DATA_W, default 8, BRAM data width.
REQ-003 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port req_valid / req_ready, input / output, 1 each, burst request handshake; accepted when both high on a clk edge.
REQ-006 Port req_write, input, 1, burst direction: 1 = write to BRAM, 0 = read from BRAM.
REQ-007 Port req_addr, input, ADDR_W, first BRAM address of the burst.
REQ-008 Port req_len, input, ADDR_W, burst length minus one (0 = 1 beat, 4095 = 4096 beats).
REQ-009 Port wr_data / wr_valid / wr_ready, input / input / output, DATA_W / 1 / 1, write beat stream.
REQ-010 Port rd_data / rd_valid / rd_ready, output / output / input, DATA_W / 1 / 1, read beat stream.
REQ-011 Port busy, output, 1, high from request acceptance until the done cycle inclusive.
REQ-012 Port done, output, 1, single-cycle pulse at burst completion.
REQ-013 Port mem_addr / mem_data / mem_wre, outputs, ADDR_W / DATA_W / 1, drive BRAM addr, data and wre.
REQ-014 Port mem_q, input, DATA_W, BRAM q; valid exactly one clk after mem_addr is presented with mem_wre = 0.

Function
REQ-015 FSM states IDLE, WRITE, READ, DRAIN; IDLE is the only state with req_ready = 1.
REQ-016 IDLE -> WRITE on an accepted request with req_write = 1; IDLE -> READ on an accepted request with req_write = 0; addr and len are latched at acceptance.
REQ-017 WRITE: wr_ready = 1; each wr_valid & wr_ready cycle drives mem_wre = 1, mem_addr = current address, mem_data = wr_data in the same cycle (combinational pass-through, zero latency).
REQ-018 WRITE: mem_wre = 0 in every cycle without a write handshake; the address advances only on a handshake.
REQ-019 WRITE -> IDLE after the last beat's handshake; done pulses in the cycle after that handshake.
REQ-020 READ: issue one read (mem_wre = 0, mem_addr = current address) per cycle whenever the output buffer occupancy plus in-flight reads is below 2.
REQ-021 Read data is captured from mem_q one cycle after issue into a 2-entry FIFO; rd_valid = FIFO not empty; rd_data = FIFO head; pop on rd_valid & rd_ready.
REQ-022 READ -> DRAIN after the last read is issued; DRAIN -> IDLE when the FIFO is empty and nothing is in flight; done pulses on that transition.
REQ-023 Full throughput: with rd_ready held high, one rd beat per cycle after a 2-cycle initial latency from acceptance.
REQ-024 Address arithmetic is modulo 2^ADDR_W: the address after 0xFFF is 0x000 with no error indication.
REQ-025 The beat counter counts down from req_len; the burst ends after the beat where the counter reaches 0.
REQ-026 A write burst never asserts rd_valid; a read burst never asserts wr_ready or mem_wre.
REQ-027 req_valid in any non-IDLE state is ignored and not queued.
REQ-028 mem_data = 0 whenever mem_wre = 0.

Reset
REQ-029 rst aborts any burst immediately; the state returns to IDLE and the FIFO and in-flight count are cleared.
REQ-030 Values during reset: req_ready = 1 after release, wr_ready = 0, rd_valid = 0, rd_data = 0, busy = 0, done = 0, mem_wre = 0, mem_addr = 0, mem_data = 0.
REQ-031 No partial beat is emitted after reset deassertion.

Structure
REQ-032 A shared package holds the FSM state enum, ADDR_W/DATA_W defaults, and the FIFO depth constant (2).
REQ-033 The 2-entry read buffer is a separate sub-module, bram_rd_fifo, with push/pop/full/empty/count ports.
REQ-034 The BRAM itself is outside this block; the bench instantiates the existing bram and connects the mem_* ports.

Verification
REQ-035 Write burst addr=0xAAA, len=0, wr_data=0xAA, then read burst addr=0xAAA, len=0 -> one rd beat 0xAA, done pulses once per burst.
REQ-036 Write burst addr=0xFFE, len=3, data 0x11,0x22,0x33,0x44 -> BRAM 0xFFE=0x11, 0xFFF=0x22, 0x000=0x33, 0x001=0x44; a read back returns the same sequence (wrap).
REQ-037 Read burst len=7 with rd_ready high -> 8 beats on consecutive cycles, first beat 2 cycles after acceptance.
REQ-038 Read burst len=7 with rd_ready toggling 1,0,0,1,... -> no beat lost or duplicated; the FIFO never exceeds 2 entries.
REQ-039 Write burst len=4 with wr_valid gaps -> mem_wre high only on handshake cycles; addresses are contiguous.
REQ-040 rst asserted mid-read after beat 3 of 8 -> all outputs at their reset values; the next burst completes normally with correct data.
